// File: rtl/hazard_fwd_unit_if.sv
// rtl/hazard_fwd_unit_if.sv - ID-stage decode bus feeding the hazard/forwarding unit
interface hazard_fwd_unit_if #(
  parameter int REG_ADDR_W = 3
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;

  // Decode stage drives the bus
  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_reg_write, id_mem_read
  );

  // Hazard unit observes the bus
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_reg_write, id_mem_read
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - load-use hazard detection and EX operand forwarding control
module hazard_fwd_unit #(
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_fwd_unit_if.slave     id,
  input  logic                 flush,
  input  logic                 hold,
  output logic [1:0]           forward_a,
  output logic [1:0]           forward_b,
  output logic                 stall,
  output logic                 ex_bubble,
  output logic [CNT_W-1:0]     stall_count
);

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_EX = 2'b10;

  // The WB-stage producer is covered by the write-through register file,
  // so only the EX and MEM occupants influence any output. MEM never needs
  // its load flag because a load in MEM forwards like any other producer.
  logic                  ex_valid_q, ex_valid_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_reg_write_q, ex_reg_write_d;
  logic                  ex_is_load_q, ex_is_load_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic                  mem_reg_write_q, mem_reg_write_d;
  logic [1:0]            fwd_a_q, fwd_a_d;
  logic [1:0]            fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic load_use, id_advance;

  function automatic logic produces(input logic v, input logic rw,
                                    input logic [REG_ADDR_W-1:0] rd,
                                    input logic [REG_ADDR_W-1:0] r);
    return v && rw && (rd == r) && (r != '0);
  endfunction

  // Youngest producer wins: EX result first, then MEM write-back data
  function automatic logic [1:0] fwd_sel(input logic used, input logic ex_hit,
                                         input logic ex_load, input logic mem_hit);
    if (!used)                return FWD_RF;
    if (ex_hit && !ex_load)   return FWD_EX;
    if (mem_hit)              return FWD_WB;
    return FWD_RF;
  endfunction

  // Hazard detection, forward selection and next-state for all trackers
  always_comb begin
    ex_hit_a  = produces(ex_valid_q, ex_reg_write_q, ex_rd_q, id.id_rs1);
    ex_hit_b  = produces(ex_valid_q, ex_reg_write_q, ex_rd_q, id.id_rs2);
    mem_hit_a = produces(mem_valid_q, mem_reg_write_q, mem_rd_q, id.id_rs1);
    mem_hit_b = produces(mem_valid_q, mem_reg_write_q, mem_rd_q, id.id_rs2);

    load_use   = ex_is_load_q && ((id.id_rs1_used && ex_hit_a) ||
                                  (id.id_rs2_used && ex_hit_b));
    stall      = !hold && id.id_valid && !flush && load_use;
    ex_bubble  = !hold && (stall || flush);
    id_advance = id.id_valid && !stall && !flush;

    ex_valid_d      = ex_valid_q;
    ex_rd_d         = ex_rd_q;
    ex_reg_write_d  = ex_reg_write_q;
    ex_is_load_d    = ex_is_load_q;
    mem_valid_d     = mem_valid_q;
    mem_rd_d        = mem_rd_q;
    mem_reg_write_d = mem_reg_write_q;
    fwd_a_d         = fwd_a_q;
    fwd_b_d         = fwd_b_q;
    stall_cnt_d     = stall_cnt_q;

    if (!hold) begin
      mem_valid_d     = ex_valid_q;
      mem_rd_d        = ex_rd_q;
      mem_reg_write_d = ex_reg_write_q;
      // A bubble still carries the ID fields, but its valid bit of 0 masks them
      ex_valid_d      = id_advance;
      ex_rd_d         = id.id_rd;
      ex_reg_write_d  = id.id_reg_write;
      ex_is_load_d    = id.id_mem_read;
      fwd_a_d = id_advance ? fwd_sel(id.id_rs1_used, ex_hit_a, ex_is_load_q, mem_hit_a) : FWD_RF;
      fwd_b_d = id_advance ? fwd_sel(id.id_rs2_used, ex_hit_b, ex_is_load_q, mem_hit_b) : FWD_RF;
      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Pipeline trackers, registered selects and stall counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q      <= 1'b0;
      ex_rd_q         <= '0;
      ex_reg_write_q  <= 1'b0;
      ex_is_load_q    <= 1'b0;
      mem_valid_q     <= 1'b0;
      mem_rd_q        <= '0;
      mem_reg_write_q <= 1'b0;
      fwd_a_q         <= FWD_RF;
      fwd_b_q         <= FWD_RF;
      stall_cnt_q     <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_rd_q         <= ex_rd_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_is_load_q    <= ex_is_load_d;
      mem_valid_q     <= mem_valid_d;
      mem_rd_q        <= mem_rd_d;
      mem_reg_write_q <= mem_reg_write_d;
      fwd_a_q         <= fwd_a_d;
      fwd_b_q         <= fwd_b_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

  assign forward_a   = fwd_a_q;
  assign forward_b   = fwd_b_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - directed and randomized check of hazard_fwd_unit against a pipeline model
module tb_hazard_fwd_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic hold = 1'b0;
  logic [1:0]  fa, fb, fa4, fb4;
  logic        stall, bub, stall4, bub4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  int n_vec = 0;
  int n_err = 0;

  hazard_fwd_unit_if #(.REG_ADDR_W(3)) bus ();

  hazard_fwd_unit #(.REG_ADDR_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst_n), .id(bus), .flush(flush), .hold(hold),
    .forward_a(fa), .forward_b(fb), .stall(stall), .ex_bubble(bub),
    .stall_count(cnt)
  );

  hazard_fwd_unit #(.REG_ADDR_W(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst_n), .id(bus), .flush(flush), .hold(hold),
    .forward_a(fa4), .forward_b(fb4), .stall(stall4), .ex_bubble(bub4),
    .stall_count(cnt4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural pipeline model ----------------
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit ld;
  } stage_t;

  stage_t pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
  int     m_fa, m_fb, m_cnt;
  int     d1, d2;
  bit     lu, adv;

  // Distance (0 = EX, 1 = MEM) of the youngest forwardable producer of r, or -1
  function automatic int youngest(input int r);
    for (int s = 0; s < 2; s++)
      if (pipe[s].v && pipe[s].rw && pipe[s].rd == r && r != 0) return s;
    return -1;
  endfunction

  function automatic int sel_of(input bit used, input int d);
    if (!used) return 0;
    if (d == 0) return 2;
    if (d == 1) return 1;
    return 0;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Compare process: checks every cycle, then advances the model to the next edge
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < 3; s++) pipe[s] = '{0, 0, 0, 0};
      m_fa = 0; m_fb = 0; m_cnt = 0;
      chk("rst_fa", int'(fa), 0);      chk("rst_fb", int'(fb), 0);
      chk("rst_stall", int'(stall), 0); chk("rst_bub", int'(bub), 0);
      chk("rst_cnt", int'(cnt), 0);    chk("rst_cnt4", int'(cnt4), 0);
    end else begin
      d1 = youngest(int'(bus.id_rs1));
      d2 = youngest(int'(bus.id_rs2));
      lu = bus.id_valid && !flush && !hold && pipe[0].ld &&
           ((bus.id_rs1_used && d1 == 0) || (bus.id_rs2_used && d2 == 0));
      chk("m_stall", int'(stall), int'(lu));
      chk("m_bub", int'(bub), int'(!hold && (lu || flush)));
      chk("m_fa", int'(fa), m_fa);
      chk("m_fb", int'(fb), m_fb);
      chk("m_cnt", int'(cnt), sat(m_cnt, 65535));
      chk("m_stall4", int'(stall4), int'(lu));
      chk("m_fa4", int'(fa4), m_fa);
      chk("m_fb4", int'(fb4), m_fb);
      chk("m_cnt4", int'(cnt4), sat(m_cnt, 15));
      if (!hold) begin
        adv = bus.id_valid && !lu && !flush;
        m_fa = adv ? sel_of(bus.id_rs1_used, d1) : 0;
        m_fb = adv ? sel_of(bus.id_rs2_used, d2) : 0;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = adv ? '{1, int'(bus.id_rd), bus.id_reg_write, bus.id_mem_read}
                      : '{0, 0, 0, 0};
        if (lu) m_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drv(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                     input int rd, input bit rw, input bit ld,
                     input bit fl = 1'b0, input bit hd = 1'b0);
    logic [2:0] a, b, c;
    a = rs1[2:0]; b = rs2[2:0]; c = rd[2:0];
    bus.id_valid = v;  bus.id_rs1 = a; bus.id_rs1_used = u1;
    bus.id_rs2 = b;    bus.id_rs2_used = u2;
    bus.id_rd = c;     bus.id_reg_write = rw; bus.id_mem_read = ld;
    flush = fl; hold = hd;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_fa", int'(fa), 0);
    chk("reset_stall", int'(stall), 0);
    chk("reset_cnt", int'(cnt), 0);

    // ALU back-to-back: ADD r1 ; SUB r2,r1,r3
    idle(2);
    drv(1, 0, 0, 0, 0, 1, 1, 0); step();
    drv(1, 1, 1, 3, 1, 2, 1, 0);
    chk("alu_b2b_stall", int'(stall), 0);
    step();
    chk("alu_b2b_fa", int'(fa), 2);
    chk("alu_b2b_fb", int'(fb), 0);

    // ALU at distance 2
    idle(2);
    drv(1, 0, 0, 0, 0, 1, 1, 0); step();
    drv(1, 0, 0, 0, 0, 6, 1, 0); step();
    drv(1, 1, 1, 3, 1, 2, 1, 0);
    chk("alu_d2_stall", int'(stall), 0);
    step();
    chk("alu_d2_fa", int'(fa), 1);

    // Load-use: LW r4 ; ADD r5,r4,r4
    idle(2);
    drv(1, 0, 0, 0, 0, 4, 1, 1); step();
    drv(1, 4, 1, 4, 1, 5, 1, 0);
    chk("lu_stall", int'(stall), 1);
    chk("lu_bub", int'(bub), 1);
    step();
    chk("lu_stall_once", int'(stall), 0);
    chk("lu_bub_once", int'(bub), 0);
    step();
    chk("lu_fa", int'(fa), 1);
    chk("lu_fb", int'(fb), 1);
    chk("lu_cnt", int'(cnt), 1);

    // r0 producer never forwards or stalls
    idle(2);
    drv(1, 0, 0, 0, 0, 0, 1, 1); step();
    drv(1, 0, 1, 0, 1, 5, 1, 0);
    chk("r0_stall", int'(stall), 0);
    step();
    chk("r0_fa", int'(fa), 0);
    chk("r0_fb", int'(fb), 0);

    // Unused rs2 matching the producer
    idle(2);
    drv(1, 0, 0, 0, 0, 3, 1, 0); step();
    drv(1, 3, 1, 3, 0, 5, 1, 0); step();
    chk("unused_fa", int'(fa), 2);
    chk("unused_fb", int'(fb), 0);

    // Flush beats a simultaneous load-use
    idle(2);
    drv(1, 0, 0, 0, 0, 4, 1, 1); step();
    drv(1, 4, 1, 4, 1, 5, 1, 0, 1'b1);
    chk("flush_stall", int'(stall), 0);
    chk("flush_bub", int'(bub), 1);
    step();
    chk("flush_fa", int'(fa), 0);
    chk("flush_fb", int'(fb), 0);
    drv(1, 4, 1, 0, 0, 5, 1, 0);
    chk("flush_ex_invalid", int'(stall), 0);

    // Double producer: youngest (EX) wins
    idle(2);
    drv(1, 0, 0, 0, 0, 1, 1, 0); step();
    drv(1, 0, 0, 0, 0, 1, 1, 0); step();
    drv(1, 1, 1, 0, 0, 2, 1, 0); step();
    chk("double_fa", int'(fa), 2);

    // Hold during a pending load-use
    idle(2);
    drv(1, 0, 0, 0, 0, 1, 1, 0); step();
    drv(1, 1, 1, 0, 0, 4, 1, 1); step();
    chk("hold_pre_fa", int'(fa), 2);
    drv(1, 4, 1, 4, 1, 5, 1, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("hold_stall", int'(stall), 0);
      chk("hold_bub", int'(bub), 0);
      step();
      chk("hold_fa", int'(fa), 2);
      chk("hold_cnt", int'(cnt), 1);
    end
    drv(1, 4, 1, 4, 1, 5, 1, 0);
    chk("hold_release_stall", int'(stall), 1);
    step();
    chk("hold_release_once", int'(stall), 0);
    chk("hold_release_cnt", int'(cnt), 2);
    step();
    chk("hold_release_fa", int'(fa), 1);

    // Asynchronous reset in the middle of a stall
    idle(2);
    drv(1, 0, 0, 0, 0, 4, 1, 1); step();
    drv(1, 4, 1, 4, 1, 5, 1, 0);
    chk("rstmid_pre_stall", int'(stall), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_stall", int'(stall), 0);
    chk("rstmid_bub", int'(bub), 0);
    chk("rstmid_fa", int'(fa), 0);
    chk("rstmid_cnt", int'(cnt), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rstmid_after_stall", int'(stall), 0);
    step();
    chk("rstmid_after_fa", int'(fa), 0);

    // 20 load-use stalls: 16-bit counter reaches 20, 4-bit one saturates at 15
    idle(2);
    for (int i = 0; i < 20; i++) begin
      drv(1, 0, 0, 0, 0, 4, 1, 1); step();
      drv(1, 4, 1, 0, 0, 5, 1, 0); step(); step();
    end
    chk("sat_cnt16", int'(cnt), 20);
    chk("sat_cnt4", int'(cnt4), 15);

    // Randomized traffic, checked by the compare process every cycle
    for (int i = 0; i < 3000; i++) begin
      drv(($urandom % 8) != 0,
          int'($urandom % 4), ($urandom % 4) != 0,
          int'($urandom % 4), ($urandom % 4) != 0,
          int'($urandom % 4), ($urandom % 5) != 0, ($urandom % 10) < 3,
          ($urandom % 10) == 0, ($urandom % 10) == 0);
      step();
    end

    idle(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
